// File: rtl/nios_ocimem_arbiter_pkg.sv
// Shared types and JTAG command-word layout for the OCI memory arbiter.
package nios_ocimem_arbiter_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_JTAG, OWN_CPU} owner_e;
  typedef enum logic [1:0] {PEND_NONE, PEND_RD, PEND_WR} pend_e;

  localparam int unsigned JDO_W        = 38;
  localparam int unsigned JDO_RD_BIT   = 1;
  localparam int unsigned JDO_ADDR_LSB = 2;
  localparam int unsigned JDO_DATA_LSB = 3;

endpackage

// File: rtl/nios_ocimem_jtag_capture.sv
// JTAG strobe decode: one-deep pending slot, post-incrementing address, sticky overrun.
module nios_ocimem_jtag_capture
  import nios_ocimem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              grant_j,
  output pend_e             pending,
  output logic [ADDR_W-1:0] jaddr,
  output logic [DATA_W-1:0] jwdata,
  output logic              overrun
);

  logic slot_free;
  logic strobe;
  logic unused_jdo;

  // The slot is reusable in the same cycle its access is granted, so
  // back-to-back strobes stream at one per cycle when JTAG owns the RAM.
  assign slot_free  = (pending == PEND_NONE) || grant_j;
  assign strobe     = take_action_ocimem_a | take_action_ocimem_b;
  assign unused_jdo = ^jdo;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= PEND_NONE;
      jaddr   <= '0;
      jwdata  <= '0;
      overrun <= 1'b0;
    end else begin
      if (grant_j) begin
        pending <= PEND_NONE;
        jaddr   <= jaddr + ADDR_W'(1);
      end
      if (strobe && !slot_free) begin
        overrun <= 1'b1;
      end else if (take_action_ocimem_b) begin
        pending <= PEND_WR;
        jwdata  <= jdo[JDO_DATA_LSB +: DATA_W];
        if (take_action_ocimem_a) overrun <= 1'b1;
      end else if (take_action_ocimem_a) begin
        jaddr <= jdo[JDO_ADDR_LSB +: ADDR_W];
        if (jdo[JDO_RD_BIT]) pending <= PEND_RD;
      end
    end
  end

endmodule

// File: rtl/nios_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG command path and the CPU slave.
module nios_ocimem_arbiter
  import nios_ocimem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned JTAG_MAX_RUN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [JDO_W-1:0]  jdo,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_ready,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned RUN_W = $clog2(JTAG_MAX_RUN + 1);

  pend_e             pending;
  logic [ADDR_W-1:0] jaddr;
  logic [DATA_W-1:0] jwdata;
  logic              cpu_req;
  logic              run_full;
  logic              grant_j;
  logic              grant_c;
  logic [RUN_W-1:0]  run_q;
  owner_e            rd_tag_q;

  nios_ocimem_jtag_capture #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_capture (
    .clk                  (clk),
    .reset                (reset),
    .take_action_ocimem_a (take_action_ocimem_a),
    .take_action_ocimem_b (take_action_ocimem_b),
    .jdo                  (jdo),
    .grant_j              (grant_j),
    .pending              (pending),
    .jaddr                (jaddr),
    .jwdata               (jwdata),
    .overrun              (jtag_overrun)
  );

  assign cpu_req  = cpu_read | cpu_write;
  assign run_full = (run_q == RUN_W'(JTAG_MAX_RUN));
  // Grants are held off while reset is high so the RAM sees no access then.
  assign grant_j  = ~reset & (pending != PEND_NONE) & ~(cpu_req & run_full);
  assign grant_c  = ~reset & cpu_req & ~grant_j;

  assign cpu_waitrequest = cpu_req & ~grant_c;

  always_comb begin
    ram_en    = grant_j | grant_c;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant_j) begin
      ram_addr  = jaddr;
      ram_we    = (pending == PEND_WR);
      ram_wdata = jwdata;
    end else if (grant_c) begin
      ram_addr  = cpu_address;
      ram_we    = cpu_write;
      ram_wdata = cpu_writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q      <= '0;
      rd_tag_q   <= OWN_NONE;
      jtag_rdata <= '0;
    end else begin
      if (grant_c || !cpu_req)   run_q <= '0;
      else if (grant_j)          run_q <= run_q + RUN_W'(1);

      if (grant_j && pending == PEND_RD) rd_tag_q <= OWN_JTAG;
      else if (grant_c && !cpu_write)    rd_tag_q <= OWN_CPU;
      else                               rd_tag_q <= OWN_NONE;

      if (rd_tag_q == OWN_JTAG) jtag_rdata <= ram_rdata;
    end
  end

  // Read data is returned straight from the RAM; reset suppresses a read in flight.
  assign cpu_readdatavalid = (rd_tag_q == OWN_CPU) & ~reset;
  assign cpu_readdata      = cpu_readdatavalid ? ram_rdata : '0;
  assign jtag_ready        = (pending == PEND_NONE) && (rd_tag_q != OWN_JTAG);

endmodule

// File: tb/tb_nios_ocimem_arbiter.sv
// Self-checking bench for nios_ocimem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_nios_ocimem_arbiter;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              take_a, take_b;
  logic [37:0]       jdo;
  logic [DATA_W-1:0] jtag_rdata;
  logic              jtag_ready, jtag_overrun;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read, cpu_write;
  logic [DATA_W-1:0] cpu_writedata, cpu_readdata;
  logic              cpu_waitrequest, cpu_readdatavalid;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_en, ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  always #5 clk = ~clk;

  nios_ocimem_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .JTAG_MAX_RUN (4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .take_action_ocimem_a (take_a),
    .take_action_ocimem_b (take_b),
    .jdo                  (jdo),
    .jtag_rdata           (jtag_rdata),
    .jtag_ready           (jtag_ready),
    .jtag_overrun         (jtag_overrun),
    .cpu_address          (cpu_address),
    .cpu_read             (cpu_read),
    .cpu_write            (cpu_write),
    .cpu_writedata        (cpu_writedata),
    .cpu_waitrequest      (cpu_waitrequest),
    .cpu_readdata         (cpu_readdata),
    .cpu_readdatavalid    (cpu_readdatavalid),
    .ram_addr             (ram_addr),
    .ram_en               (ram_en),
    .ram_we               (ram_we),
    .ram_wdata            (ram_wdata),
    .ram_rdata            (ram_rdata)
  );

  // Behavioural RAM; pre_we gives the bench a private preload path.
  logic [DATA_W-1:0] mem [0:255];
  logic              pre_we = 1'b0;
  logic [7:0]        pre_addr = '0;
  logic [31:0]       pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned rdv_count = 0;
  logic [31:0] sb_q[$];
  byte         glog[$];
  logic        log_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard and grant logger
  always @(negedge clk) begin
    if (cpu_readdatavalid) begin
      rdv_count++;
      if (sb_q.size() == 0) check("cpu_rdv_unexpected", 64'(cpu_readdatavalid), 64'd0);
      else                  check("cpu_rdata", 64'(cpu_readdata), 64'(sb_q.pop_front()));
    end
    if (log_en && ram_en)
      glog.push_back(((cpu_read | cpu_write) & ~cpu_waitrequest) ? byte'("C") : byte'("J"));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd);
    logic [37:0] v;
    v = '0; v[9:2] = a; v[1] = rd;
    return v;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] v;
    v = '0; v[34:3] = d;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_jtag_rdata"}, 64'(jtag_rdata), 64'd0);
    check({tag, "_jtag_ready"}, 64'(jtag_ready), 64'd1);
    check({tag, "_overrun"},    64'(jtag_overrun), 64'd0);
    check({tag, "_rdv"},        64'(cpu_readdatavalid), 64'd0);
    check({tag, "_readdata"},   64'(cpu_readdata), 64'd0);
    check({tag, "_ram_en"},     64'(ram_en), 64'd0);
    check({tag, "_ram_we"},     64'(ram_we), 64'd0);
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] pre;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_next;
    logic [31:0] wdata;
  } jvec_t;

  initial begin
    jvec_t       jv[4];
    string       exp_pat;
    int unsigned rdv_base, waits;

    jv[0] = '{8'h10, 32'hCAFEF00D, 32'hCAFEF00D, 8'h11, 32'h1111_0001};
    jv[1] = '{8'h00, 32'h0000_0000, 32'h0000_0000, 8'h01, 32'h2222_0002};
    jv[2] = '{8'h7F, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 8'h80, 32'h3333_0003};
    jv[3] = '{8'hFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 8'h00, 32'h4444_0004};

    reset = 1'b1; take_a = 1'b0; take_b = 1'b0; jdo = '0;
    cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_writedata = '0;
    step(); step();
    @(negedge clk);
    check_reset_vals("rst");
    step();
    reset = 1'b0;

    // JTAG reads driven from the vector table, each followed by a write that
    // must land at the post-incremented address.
    for (int i = 0; i < 4; i++) begin
      preload(jv[i].addr, jv[i].pre);
      preload(jv[i].exp_next, 32'h0);
      take_a = 1'b1; jdo = jdo_a(jv[i].addr, 1'b1);
      @(negedge clk);
      check("jrd_t0_en", 64'(ram_en), 64'd0);
      check("jrd_t0_ready", 64'(jtag_ready), 64'd1);
      step();
      take_a = 1'b0;
      @(negedge clk);
      check("jrd_t1_en", 64'(ram_en), 64'd1);
      check("jrd_t1_we", 64'(ram_we), 64'd0);
      check("jrd_t1_addr", 64'(ram_addr), 64'(jv[i].addr));
      check("jrd_t1_ready", 64'(jtag_ready), 64'd0);
      step();
      @(negedge clk);
      check("jrd_t2_ready", 64'(jtag_ready), 64'd0);
      step();
      @(negedge clk);
      check("jrd_t3_rdata", 64'(jtag_rdata), 64'(jv[i].exp_rdata));
      check("jrd_t3_ready", 64'(jtag_ready), 64'd1);
      step();
      take_b = 1'b1; jdo = jdo_b(jv[i].wdata);
      step();
      take_b = 1'b0;
      step(); step();
      check("jaddr_incr_write", 64'(mem[jv[i].exp_next]), 64'(jv[i].wdata));
    end

    // CPU alone: four back-to-back reads
    for (int i = 0; i < 4; i++) preload(8'(i), 32'h3C00_0000 + 32'(i));
    rdv_base = rdv_count;
    for (int i = 0; i < 4; i++) begin
      cpu_read = 1'b1; cpu_address = 8'(i);
      sb_q.push_back(32'h3C00_0000 + 32'(i));
      @(negedge clk);
      check("cpu_b2b_wait", 64'(cpu_waitrequest), 64'd0);
      check("cpu_b2b_en", 64'(ram_en), 64'd1);
      step();
    end
    cpu_read = 1'b0;
    step(); step();
    check("cpu_b2b_rdv_count", 64'(rdv_count - rdv_base), 64'd4);

    // CPU write, then read+write together (write wins, no read return)
    cpu_write = 1'b1; cpu_address = 8'h20; cpu_writedata = 32'h5151_A0A0;
    step();
    cpu_write = 1'b0;
    step();
    check("cpu_write", 64'(mem[8'h20]), 64'h5151_A0A0);
    rdv_base = rdv_count;
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 8'h21; cpu_writedata = 32'h0F0F_1234;
    @(negedge clk);
    check("cpu_rw_we", 64'(ram_we), 64'd1);
    step();
    cpu_read = 1'b0; cpu_write = 1'b0;
    step(); step();
    check("cpu_rw_mem", 64'(mem[8'h21]), 64'h0F0F_1234);
    check("cpu_rw_no_rdv", 64'(rdv_count - rdv_base), 64'd0);

    // Contention with run limit 4, plus overrun while the CPU holds the grant
    do_reset();
    check("pre_contention_overrun", 64'(jtag_overrun), 64'd0);
    for (int i = 0; i < 8; i++) preload(8'h40 + 8'(i), 32'h0);
    preload(8'h05, 32'h7777_0005);
    take_a = 1'b1; jdo = jdo_a(8'h40, 1'b0);
    step();
    take_a = 1'b0;
    waits = 0;
    log_en = 1'b1;
    for (int c = 0; c < 9; c++) begin
      take_b = 1'b0;
      if (c <= 4 || c == 6) begin
        take_b = 1'b1;
        jdo = jdo_b(32'hB0B0_0000 + 32'(c == 6 ? 5 : c));
      end else if (c == 5) begin
        take_b = 1'b1;
        jdo = jdo_b(32'hBAD0_0BAD);
      end
      if (c == 1) begin
        cpu_read = 1'b1; cpu_address = 8'h05;
        sb_q.push_back(32'h7777_0005);
      end
      @(negedge clk);
      if (cpu_read && cpu_waitrequest) waits++;
      if (c == 5) check("contention_cpu_granted", 64'(cpu_waitrequest), 64'd0);
      step();
      if (c == 5) begin
        cpu_read = 1'b0;
        check("overrun_set", 64'(jtag_overrun), 64'd1);
      end
    end
    take_b = 1'b0;
    log_en = 1'b0;
    step();
    check("contention_waits", 64'(waits), 64'd4);
    exp_pat = "JJJJCJJ";
    check("grant_pat_len", 64'(glog.size()), 64'(exp_pat.len()));
    for (int i = 0; i < exp_pat.len() && i < glog.size(); i++)
      check("grant_pat", 64'(glog[i]), 64'(exp_pat[i]));
    for (int i = 0; i < 6; i++)
      check("contention_write", 64'(mem[8'h40 + 8'(i)]), 64'(32'hB0B0_0000 + 32'(i)));
    check("dropped_write_absent", 64'(mem[8'h46]), 64'd0);
    check("overrun_sticky", 64'(jtag_overrun), 64'd1);

    // Strobes a and b together: b wins, overrun flagged
    do_reset();
    take_a = 1'b1; take_b = 1'b1; jdo = jdo_b(32'h1234_5678) | jdo_a(8'h33, 1'b1);
    step();
    take_a = 1'b0; take_b = 1'b0;
    @(negedge clk);
    check("ab_same_we", 64'(ram_we), 64'd1);
    check("ab_same_overrun", 64'(jtag_overrun), 64'd1);
    step(); step();

    // Address wrap 0xFF -> 0x00
    do_reset();
    preload(8'hFF, 32'h0); preload(8'h00, 32'h0);
    take_a = 1'b1; jdo = jdo_a(8'hFF, 1'b0);
    step();
    take_a = 1'b0; take_b = 1'b1; jdo = jdo_b(32'hF00D_00FF);
    step();
    take_b = 1'b0;
    step();
    take_b = 1'b1; jdo = jdo_b(32'hF00D_0000);
    step();
    take_b = 1'b0;
    step(); step();
    check("wrap_ff", 64'(mem[8'hFF]), 64'hF00D_00FF);
    check("wrap_00", 64'(mem[8'h00]), 64'hF00D_0000);
    check("wrap_overrun", 64'(jtag_overrun), 64'd0);

    // Reset the cycle after a CPU read grant: read is discarded
    rdv_base = rdv_count;
    cpu_read = 1'b1; cpu_address = 8'h02;
    @(negedge clk);
    check("rst_mid_grant", 64'(ram_en), 64'd1);
    step();
    cpu_read = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rst_mid_rdv", 64'(cpu_readdatavalid), 64'd0);
    step();
    @(negedge clk);
    check_reset_vals("rst_mid");
    step();
    reset = 1'b0;
    step(); step();
    check("rst_mid_no_rdv", 64'(rdv_count - rdv_base), 64'd0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
